seg_roll_sequencer: RTL and testbench
=====================================

# seg_roll_sequencer

Sequencer for one seven-segment digit's vertical row shifter. It animates a change of displayed character as an odometer-style roll: the old glyph slides out one row per step, the digit goes blank, then the new glyph slides in from the opposite edge. It sits between the character-select logic and the shifter, and drives the shifter's character, amount and direction inputs.

## Interface
- STEP_CYCLES, 2500000: clock cycles each animation step is held (50 ms at 50 MHz); legal range is 1 to 2^24−1.
- RESET_CHAR, 7'b1111111: glyph presented after reset (segments are active-low, so this is all segments off).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle request to roll to char_in.
- dir  in  1  sampled together with load. 1 = roll up (old glyph exits through the top, new glyph enters from the bottom). 0 = roll down.
- char_in  in  7  target glyph, active-low segments.
- char_out  out  7  glyph driven to the shifter's char input.
- amt  out  3  row-shift amount driven to the shifter; only values 0..3 are ever driven.
- up  out  1  shift direction driven to the shifter.
- busy  out  1  high while an animation is in progress.
- done  out  1  one-cycle pulse when an animation completes.

## Operation
- Registers: cur (glyph currently shown), tgt (glyph being rolled in), rdir, pend_valid, pend_char, pend_dir, step counter (24 bits), and state.
- States and their outputs:
  - IDLE: char_out=cur, amt=0, up=0.
  - S1: char_out=cur, amt=1, up=rdir.
  - S2: char_out=cur, amt=2, up=rdir.
  - S3: char_out=cur, amt=3, up=rdir.
  - S4: char_out=tgt, amt=2, up=~rdir.
  - S5: char_out=tgt, amt=1, up=~rdir.
- IDLE handling of load:
  - If char_in ≠ cur: capture tgt=char_in and rdir=dir, then go to S1.
  - If char_in = cur: ignore the request. No busy, no done.
- Step sequencing:
  - Each of S1–S5 lasts exactly STEP_CYCLES cycles; the counter clears on every state entry.
  - S5 expiry sets cur=tgt and asserts done for one cycle.
  - If pend_valid is clear, go to IDLE.
  - If pend_valid is set and pend_char ≠ the new cur: set tgt=pend_char, rdir=pend_dir, clear pend_valid, and go straight to S1.
  - If pend_valid is set and pend_char = the new cur: clear pend_valid and go to IDLE.
- Load while busy:
  - Store char_in and dir into the one-deep pending slot and set pend_valid.
  - A later load overwrites the slot; only the most recent request survives.
  - The animation in flight is never altered.
- Load in the same cycle S5 expires: this counts as load-while-busy, so it goes to the pending slot and the chained decision above uses it in that same transition.
- busy = (state ≠ IDLE).
- Reset, asynchronous, including mid-animation:
  - state=IDLE, cur=RESET_CHAR, tgt=RESET_CHAR, pend_valid=0, counter=0.
  - Outputs: char_out=RESET_CHAR, amt=0, up=0, busy=0, done=0.
  - Any animation in flight is abandoned; its target is lost.

## Timing
- All outputs are registered or decoded purely from registered state; there is no combinational path from any input to any output.
- Load accepted in IDLE at edge k: S1 outputs are visible after edge k; busy=1 from that point.
- busy is high for exactly 5·STEP_CYCLES cycles per animation.
- done is high in the single cycle following the final S5 cycle. In that same cycle:
  - unchained: state is IDLE with char_out=tgt, amt=0;
  - chained: S1 outputs with char_out equal to the just-completed glyph, and busy stays continuously high.
- Latency from accepted load to final glyph displayed at amt=0 is 5·STEP_CYCLES+1 edges.
- With STEP_CYCLES=1 every state lasts one cycle; no state is skipped.

## Test plan
- Use STEP_CYCLES=4 throughout.
- Reset check: assert reset mid-cycle, without a clock edge → immediately char_out=7'h7F, amt=0, busy=0, done=0.
- Basic roll up: from reset, load char_in=7'h40 with dir=1 → amt sequence 1,2,3 (char_out=7'h7F, up=1) then 2,1 (char_out=7'h40, up=0), each held 4 cycles; then done pulses once, amt=0, char_out=7'h40; busy was high for 20 cycles.
- Roll down: with cur=7'h40, load 7'h79 with dir=0 → S1–S3 have up=0, S4–S5 have up=1; final char_out=7'h79.
- Same-glyph load: with cur=7'h79, load 7'h79 → busy stays 0, done never pulses, outputs unchanged.
- Chained with overwrite: with cur=7'h79, load 7'h24, then 7'h30 in S2, then 7'h19 in S4 → after the first roll completes (done pulse), S1 starts immediately and busy never drops; the second roll ends at 7'h19; 7'h30 is never shown at amt<3; exactly two done pulses.
- Reset mid-roll: assert reset during S3 → async return to IDLE with char_out=7'h7F; after release, no done pulse and no resumption of the abandoned roll.

Source files
------------

// File: rtl/seg_roll_sequencer.sv
// seg_roll_sequencer
// Drives one seven-segment digit's row shifter so that a character change is
// shown as an odometer roll: the old glyph slides out, the digit blanks, and
// the new glyph slides in from the opposite edge. A one-deep pending slot
// holds the latest request made while a roll is in flight, so back-to-back
// rolls chain without a visible idle gap. All outputs come straight from
// flops, so no input reaches an output combinationally.

module seg_roll_sequencer #(
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter logic [6:0]  RESET_CHAR  = 7'b1111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dir,
  input  logic [6:0] char_in,
  output logic [6:0] char_out,
  output logic [2:0] amt,
  output logic       up,
  output logic       busy,
  output logic       done
);

  // Terminal count of the per-step counter (step lasts STEP_CYCLES cycles).
  localparam logic [23:0] STEP_LAST = 24'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5
  } state_t;

  // Shifter drive for a given state: {char[6:0], amt[2:0], up}.
  // S1..S3 push the old glyph out in the roll direction; S4..S5 bring the
  // new glyph back in from the opposite edge, hence the inverted direction.
  function automatic logic [10:0] decode_out(input state_t st,
                                             input logic [6:0] cur_g,
                                             input logic [6:0] tgt_g,
                                             input logic rd);
    logic [10:0] res;
    case (st)
      IDLE:    res = {cur_g, 3'd0, 1'b0};
      S1:      res = {cur_g, 3'd1, rd};
      S2:      res = {cur_g, 3'd2, rd};
      S3:      res = {cur_g, 3'd3, rd};
      S4:      res = {tgt_g, 3'd2, ~rd};
      S5:      res = {tgt_g, 3'd1, ~rd};
      default: res = {cur_g, 3'd0, 1'b0};
    endcase
    return res;
  endfunction

  state_t      state_r, state_s;
  logic [6:0]  cur_r, cur_s;
  logic [6:0]  tgt_r, tgt_s;
  logic        rdir_r, rdir_s;
  logic        pend_valid_r, pend_valid_s;
  logic [6:0]  pend_char_r, pend_char_s;
  logic        pend_dir_r, pend_dir_s;
  logic [23:0] cnt_r, cnt_s;

  logic [6:0]  char_out_r;
  logic [2:0]  amt_r;
  logic        up_r, busy_r, done_r;

  logic        expire_s;
  logic        eff_valid_s;
  logic [6:0]  eff_char_s;
  logic        eff_dir_s;
  logic [10:0] drive_s;
  logic        done_s;

  // Next-state, datapath and pending-slot logic for the roll sequence.
  always_comb begin
    state_s      = state_r;
    cur_s        = cur_r;
    tgt_s        = tgt_r;
    rdir_s       = rdir_r;
    pend_valid_s = pend_valid_r;
    pend_char_s  = pend_char_r;
    pend_dir_s   = pend_dir_r;
    cnt_s        = cnt_r;
    done_s       = 1'b0;
    expire_s     = (cnt_r == STEP_LAST);
    // A load arriving on the final S5 cycle takes part in the chain decision.
    eff_valid_s  = pend_valid_r | load;
    eff_char_s   = load ? char_in : pend_char_r;
    eff_dir_s    = load ? dir : pend_dir_r;

    case (state_r)
      IDLE: begin
        cnt_s = 24'd0;
        if (load && (char_in != cur_r)) begin
          tgt_s   = char_in;
          rdir_s  = dir;
          state_s = S1;
        end else begin
          state_s = IDLE;
        end
      end

      S1, S2, S3, S4: begin
        if (load) begin
          pend_valid_s = 1'b1;
          pend_char_s  = char_in;
          pend_dir_s   = dir;
        end else begin
          pend_valid_s = pend_valid_r;
        end
        if (expire_s) begin
          cnt_s = 24'd0;
          case (state_r)
            S1:      state_s = S2;
            S2:      state_s = S3;
            S3:      state_s = S4;
            S4:      state_s = S5;
            default: state_s = IDLE;
          endcase
        end else begin
          cnt_s = cnt_r + 24'd1;
        end
      end

      S5: begin
        if (expire_s) begin
          cnt_s        = 24'd0;
          cur_s        = tgt_r;
          done_s       = 1'b1;
          pend_valid_s = 1'b0;
          pend_char_s  = eff_char_s;
          pend_dir_s   = eff_dir_s;
          if (eff_valid_s && (eff_char_s != tgt_r)) begin
            tgt_s   = eff_char_s;
            rdir_s  = eff_dir_s;
            state_s = S1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + 24'd1;
          if (load) begin
            pend_valid_s = 1'b1;
            pend_char_s  = char_in;
            pend_dir_s   = dir;
          end else begin
            pend_valid_s = pend_valid_r;
          end
        end
      end

      default: begin
        state_s      = IDLE;
        cnt_s        = 24'd0;
        pend_valid_s = 1'b0;
      end
    endcase

    drive_s = decode_out(state_s, cur_s, tgt_s, rdir_s);
  end

  // State and datapath registers; reset abandons any roll in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cur_r        <= RESET_CHAR;
      tgt_r        <= RESET_CHAR;
      rdir_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_char_r  <= RESET_CHAR;
      pend_dir_r   <= 1'b0;
      cnt_r        <= 24'd0;
    end else begin
      state_r      <= state_s;
      cur_r        <= cur_s;
      tgt_r        <= tgt_s;
      rdir_r       <= rdir_s;
      pend_valid_r <= pend_valid_s;
      pend_char_r  <= pend_char_s;
      pend_dir_r   <= pend_dir_s;
      cnt_r        <= cnt_s;
    end
  end

  // Output registers, loaded from the decode of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_out_r <= RESET_CHAR;
      amt_r      <= 3'd0;
      up_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      char_out_r <= drive_s[10:4];
      amt_r      <= drive_s[3:1];
      up_r       <= drive_s[0];
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
    end
  end

  assign char_out = char_out_r;
  assign amt      = amt_r;
  assign up       = up_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_seg_roll_sequencer.sv
// Scoreboard bench for seg_roll_sequencer with STEP_CYCLES=4. Stimulus pushes
// the expected per-cycle output tuple {char_out, amt, up, busy, done} into a
// queue; an independent monitor pops one entry per cycle and compares.

module tb_seg_roll_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       dir = 1'b0;
  logic [6:0] char_in = 7'h00;
  logic [6:0] char_out;
  logic [2:0] amt;
  logic       up, busy, done;

  logic [12:0] sb_q[$];
  logic [12:0] mon_exp;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  string       cur_test = "init";

  seg_roll_sequencer #(.STEP_CYCLES(4), .RESET_CHAR(7'h7F)) dut (
    .clk(clk), .reset(reset), .load(load), .dir(dir), .char_in(char_in),
    .char_out(char_out), .amt(amt), .up(up), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic [6:0] c, input logic [2:0] a,
                                     input logic u, input logic b, input logic d);
    return {c, a, u, b, d};
  endfunction

  task automatic check_tuple(input string name, input logic [12:0] exp);
    logic [12:0] got;
    got = {char_out, amt, up, busy, done};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got char_out=%h amt=%0d up=%b busy=%b done=%b, expected char_out=%h amt=%0d up=%b busy=%b done=%b",
               name, got[12:6], got[5:3], got[2], got[1], got[0],
               exp[12:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_n(input logic [12:0] t, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(t);
  endtask

  // Full unchained roll from glyph c0 to c1 in direction d, ending on done.
  task automatic push_roll(input logic [6:0] c0, input logic [6:0] c1, input logic d);
    push_n(mk(c0, 3'd1, d, 1'b1, 1'b0), 4);
    push_n(mk(c0, 3'd2, d, 1'b1, 1'b0), 4);
    push_n(mk(c0, 3'd3, d, 1'b1, 1'b0), 4);
    push_n(mk(c1, 3'd2, ~d, 1'b1, 1'b0), 4);
    push_n(mk(c1, 3'd1, ~d, 1'b1, 1'b0), 4);
    push_n(mk(c1, 3'd0, 1'b0, 1'b0, 1'b1), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d entries left, expected 0", cur_test, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: one scoreboard comparison per cycle, plus busy/done tallies.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check_tuple(cur_test, mon_exp);
      end
      if (!reset) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  // Stimulus
  initial begin
    // asynchronous reset, no clock edge yet
    #3 reset = 1'b1;
    #1 check_tuple("reset_async", mk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // roll up 7F -> 40
    @(negedge clk);
    cur_test = "roll_up"; busy_cnt = 0; done_cnt = 0;
    push_n(mk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0), 1);
    push_roll(7'h7F, 7'h40, 1'b1);
    push_n(mk(7'h40, 3'd0, 1'b0, 1'b0, 1'b0), 2);
    load = 1'b1; char_in = 7'h40; dir = 1'b1;
    @(negedge clk); load = 1'b0;
    drain();
    check_int("roll_up_busy_cycles", busy_cnt, 20);
    check_int("roll_up_done_pulses", done_cnt, 1);

    // roll down 40 -> 79
    @(negedge clk);
    cur_test = "roll_down"; busy_cnt = 0; done_cnt = 0;
    push_n(mk(7'h40, 3'd0, 1'b0, 1'b0, 1'b0), 1);
    push_roll(7'h40, 7'h79, 1'b0);
    push_n(mk(7'h79, 3'd0, 1'b0, 1'b0, 1'b0), 2);
    load = 1'b1; char_in = 7'h79; dir = 1'b0;
    @(negedge clk); load = 1'b0;
    drain();
    check_int("roll_down_busy_cycles", busy_cnt, 20);
    check_int("roll_down_done_pulses", done_cnt, 1);

    // same glyph: ignored
    @(negedge clk);
    cur_test = "same_glyph"; busy_cnt = 0; done_cnt = 0;
    push_n(mk(7'h79, 3'd0, 1'b0, 1'b0, 1'b0), 6);
    load = 1'b1; char_in = 7'h79; dir = 1'b1;
    @(negedge clk); load = 1'b0;
    drain();
    check_int("same_glyph_busy_cycles", busy_cnt, 0);
    check_int("same_glyph_done_pulses", done_cnt, 0);

    // chained with overwrite: 24 (up), 30 in S2, 19 (down) in S4
    @(negedge clk);
    cur_test = "chained"; busy_cnt = 0; done_cnt = 0;
    push_n(mk(7'h79, 3'd0, 1'b0, 1'b0, 1'b0), 1);
    push_n(mk(7'h79, 3'd1, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h79, 3'd2, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h79, 3'd3, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h24, 3'd2, 1'b0, 1'b1, 1'b0), 4);
    push_n(mk(7'h24, 3'd1, 1'b0, 1'b1, 1'b0), 4);
    push_n(mk(7'h24, 3'd1, 1'b0, 1'b1, 1'b1), 1);
    push_n(mk(7'h24, 3'd1, 1'b0, 1'b1, 1'b0), 3);
    push_n(mk(7'h24, 3'd2, 1'b0, 1'b1, 1'b0), 4);
    push_n(mk(7'h24, 3'd3, 1'b0, 1'b1, 1'b0), 4);
    push_n(mk(7'h19, 3'd2, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h19, 3'd1, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h19, 3'd0, 1'b0, 1'b0, 1'b1), 1);
    push_n(mk(7'h19, 3'd0, 1'b0, 1'b0, 1'b0), 2);
    load = 1'b1; char_in = 7'h24; dir = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (5) @(negedge clk);
    load = 1'b1; char_in = 7'h30; dir = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (7) @(negedge clk);
    load = 1'b1; char_in = 7'h19; dir = 1'b0;
    @(negedge clk); load = 1'b0;
    drain();
    check_int("chained_busy_cycles", busy_cnt, 40);
    check_int("chained_done_pulses", done_cnt, 2);

    // reset in the middle of S3
    @(negedge clk);
    cur_test = "reset_mid_roll";
    push_n(mk(7'h19, 3'd0, 1'b0, 1'b0, 1'b0), 1);
    push_n(mk(7'h19, 3'd1, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h19, 3'd2, 1'b1, 1'b1, 1'b0), 4);
    push_n(mk(7'h19, 3'd3, 1'b1, 1'b1, 1'b0), 2);
    load = 1'b1; char_in = 7'h40; dir = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (9) @(negedge clk);
    #3 reset = 1'b1;
    #1 check_tuple("reset_mid_roll_async", mk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cur_test = "after_reset"; busy_cnt = 0; done_cnt = 0;
    push_n(mk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0), 30);
    drain();
    check_int("after_reset_busy_cycles", busy_cnt, 0);
    check_int("after_reset_done_pulses", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
